// File: rtl/usbfs_rx_rdarb.sv
// usbfs_rx_rdarb: round-robin arbiter for the shared USB FS RX packet-buffer
// read port. A grant is held for a whole packet drain and released on the
// owner's last read. Read data returns one cycle after o_erRdEn and is routed
// back by the owner registered at issue time.
// Optional feature: define USBFS_RDARB_TIMEOUT_EN to force-release an owner
// that has stalled for TIMEOUT consecutive cycles.
module usbfs_rx_rdarb #(
  parameter int N_REQ   = 2,
  parameter int MAX_PKT = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [N_REQ-1:0]                   i_reqRdEn,
  input  logic [N_REQ*$clog2(MAX_PKT)-1:0]   i_reqRdIdx,
  input  logic [N_REQ-1:0]                   i_reqLast,
  output logic [N_REQ-1:0]                   o_reqGnt,
  output logic [N_REQ-1:0]                   o_reqRdValid,
  output logic [7:0]                         o_reqRdByte,
  output logic                               o_erRdEn,
  output logic [$clog2(MAX_PKT)-1:0]         o_erRdIdx,
  input  logic [7:0]                         i_erRdByte,
  output logic                               o_busy,
  output logic                               o_timeout
);

  localparam int IW = $clog2(MAX_PKT);
  localparam int OW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, OWNED} state_t;

  state_t        state, nxt_state;
  logic [OW-1:0] owner, nxt_owner;
  logic [OW-1:0] rr_ptr, nxt_rr;
  logic [OW-1:0] win_idx, cand;
  logic          own_rd, own_last, to_hit;

  // Only the current owner can reach the buffer; everyone else is ignored.
  assign own_rd      = (state == OWNED) && i_reqRdEn[owner];
  assign own_last    = i_reqLast[owner];
  assign o_erRdEn    = own_rd;
  assign o_erRdIdx   = i_reqRdIdx[owner*IW +: IW];
  assign o_reqRdByte = i_erRdByte;
  assign o_busy      = (state == OWNED);

  // Round-robin pick: first requester after rr_ptr. Scanning from the far end
  // lets the nearest candidate overwrite, so no early exit is needed.
  always_comb begin
    win_idx = rr_ptr;
    cand    = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = OW'((int'(rr_ptr) + i) % N_REQ);
      if (i_reqRdEn[cand]) win_idx = cand;
    end
  end

  // Next-state logic: arbitrate in IDLE, hold the grant in OWNED until the
  // owner's last read (or a forced release).
  always_comb begin
    nxt_state = state;
    nxt_owner = owner;
    nxt_rr    = rr_ptr;
    case (state)
      IDLE: begin
        if (|i_reqRdEn) begin
          nxt_state = OWNED;
          nxt_owner = win_idx;
        end
      end
      OWNED: begin
        if ((own_rd && own_last) || to_hit) begin
          nxt_state = IDLE;
          nxt_rr    = owner;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // State, owner and round-robin pointer registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= OW'(N_REQ - 1);
    end else begin
      state  <= nxt_state;
      owner  <= nxt_owner;
      rr_ptr <= nxt_rr;
    end
  end

  // Registered grant, and the read-return strobe routed by the issuing owner.
  // Reset clears the strobe so data in flight is dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_reqGnt     <= '0;
      o_reqRdValid <= '0;
    end else begin
      o_reqGnt     <= (nxt_state == OWNED) ? (ONE << nxt_owner) : '0;
      o_reqRdValid <= own_rd ? (ONE << owner) : '0;
    end
  end

`ifdef USBFS_RDARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] idle_cnt;

  // Fires on the TIMEOUT-th consecutive owner stall cycle.
  assign to_hit = (state == OWNED) && !i_reqRdEn[owner] &&
                  (idle_cnt == CW'(TIMEOUT - 1));

  // Stall counter: counts owner idle cycles, cleared by any owner read or
  // by leaving OWNED.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      idle_cnt <= '0;
    else if ((state != OWNED) || own_rd || (nxt_state != OWNED))
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end

  // One-cycle pulse in the first IDLE cycle after a forced release.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_timeout <= 1'b0;
    else       o_timeout <= to_hit;
  end
`else
  // Never true: the stall counter is compiled out and the grant is held.
  assign to_hit    = (TIMEOUT < 0);
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_usbfs_rx_rdarb.sv
// Bench for usbfs_rx_rdarb (N_REQ=4): directed scenarios plus a random soak,
// checked against a transaction-level model of grant ownership and reads.
module tb_usbfs_rx_rdarb;
  localparam int N  = 4;
  localparam int IW = 3;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  rden = '0, last = '0;
  logic [N*IW-1:0] idx = '0;
  logic [N-1:0]  gnt, rdv;
  logic [7:0]    rd_byte, er_byte;
  logic          er_en, busy, tmo;
  logic [IW-1:0] er_idx;

  int total = 0, bad = 0;
  logic [7:0] mem [8];

  usbfs_rx_rdarb #(.N_REQ(N), .MAX_PKT(8), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_reqRdEn(rden), .i_reqRdIdx(idx),
    .i_reqLast(last), .o_reqGnt(gnt), .o_reqRdValid(rdv),
    .o_reqRdByte(rd_byte), .o_erRdEn(er_en), .o_erRdIdx(er_idx),
    .i_erRdByte(er_byte), .o_busy(busy), .o_timeout(tmo));

  always #5 clk = ~clk;

  // Packet buffer with 1-cycle read latency.
  always @(posedge clk) if (er_en) er_byte <= mem[er_idx];

  // ---------------- reference model ----------------
  int         m_owner, m_rr, m_cnt, m_powner;
  bit         m_pend, m_to;
  logic [2:0] m_pidx;

  function automatic int pick(int rr, logic [N-1:0] r);
    for (int i = 1; i <= N; i++) if (r[(rr + i) % N]) return (rr + i) % N;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= -1; m_rr <= N - 1; m_cnt <= 0; m_pend <= 1'b0;
      m_to <= 1'b0; m_powner <= 0; m_pidx <= '0;
    end else begin
      m_to   <= 1'b0;
      m_pend <= (m_owner >= 0) && rden[m_owner];
      if (m_owner >= 0) begin
        m_powner <= m_owner;
        m_pidx   <= idx[m_owner*IW +: IW];
      end
      if (m_owner < 0) begin
        m_cnt <= 0;
        if (rden != '0) m_owner <= pick(m_rr, rden);
      end else begin
        if (rden[m_owner]) m_cnt <= 0; else m_cnt <= m_cnt + 1;
        if (rden[m_owner] && last[m_owner]) begin
          m_rr <= m_owner; m_owner <= -1;
        end
`ifdef USBFS_RDARB_TIMEOUT_EN
        else if (!rden[m_owner] && (m_cnt + 1 >= TO)) begin
          m_rr <= m_owner; m_owner <= -1; m_to <= 1'b1; m_cnt <= 0;
        end
`endif
      end
    end
  end

  // Every cycle: DUT vs model, plus structural invariants.
  always @(negedge clk) begin
    logic [N-1:0] eg, ev;
    logic         ee;
    if (!rst) begin
      eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
      ee = (m_owner >= 0) && rden[m_owner];
      ev = m_pend ? (N'(1) << m_powner) : '0;
      total++; if (gnt !== eg) begin bad++; $display("FAIL mon_gnt got=%b exp=%b t=%0t", gnt, eg, $time); end
      total++; if (er_en !== ee) begin bad++; $display("FAIL mon_rden got=%b exp=%b t=%0t", er_en, ee, $time); end
      total++; if (busy !== (m_owner >= 0)) begin bad++; $display("FAIL mon_busy got=%b t=%0t", busy, $time); end
      total++; if (rdv !== ev) begin bad++; $display("FAIL mon_rdvalid got=%b exp=%b t=%0t", rdv, ev, $time); end
      total++; if (tmo !== m_to) begin bad++; $display("FAIL mon_timeout got=%b exp=%b t=%0t", tmo, m_to, $time); end
      if (ee) begin
        total++;
        if (er_idx !== idx[m_owner*IW +: IW]) begin bad++; $display("FAIL mon_idx got=%0d t=%0t", er_idx, $time); end
      end
      if (m_pend) begin
        total++;
        if (rd_byte !== mem[m_pidx]) begin bad++; $display("FAIL mon_byte got=%h exp=%h t=%0t", rd_byte, mem[m_pidx], $time); end
      end
      total++; if (!$onehot0(gnt)) begin bad++; $display("FAIL mon_onehot gnt=%b t=%0t", gnt, $time); end
      if (er_en) begin
        total++; if (!$onehot(gnt)) begin bad++; $display("FAIL mon_en_no_gnt gnt=%b t=%0t", gnt, $time); end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    total++; if ({gnt, rdv, er_en, busy, tmo} !== '0) begin bad++; $display("FAIL reset_outputs got=%b exp=0", {gnt, rdv, er_en, busy, tmo}); end
    @(posedge clk); #3 rst = 1'b0;
    step();
    total++; if (gnt !== '0) begin bad++; $display("FAIL reset_idle_gnt got=%b exp=0", gnt); end
  endtask

  task automatic test_single();
    rden[1] = 1'b1; idx[1*IW +: IW] = 3'd0;
    #1 total++; if (er_en !== 1'b0) begin bad++; $display("FAIL single_noread_idle got=%b exp=0", er_en); end
    step();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL single_gnt got=%b exp=0010", gnt); end
    for (int k = 0; k < 4; k++) begin
      idx[1*IW +: IW] = 3'(k); last[1] = (k == 3);
      #1 total++; if (er_en !== 1'b1 || er_idx !== 3'(k)) begin bad++; $display("FAIL single_read got=%b/%0d exp=1/%0d", er_en, er_idx, k); end
      step();
      total++; if (rdv !== 4'b0010 || rd_byte !== mem[k]) begin bad++; $display("FAIL single_ret got=%b/%h exp=0010/%h", rdv, rd_byte, mem[k]); end
    end
    rden = '0; last = '0;
    total++; if (gnt !== '0) begin bad++; $display("FAIL single_release got=%b exp=0", gnt); end
    step();
  endtask

  task automatic test_alternate();
    int pos [2];
    int ord [4];
    int nb, cyc, idle_run, own;
    logic [N-1:0] g;
    pos = '{0, 0}; ord = '{-1, -1, -1, -1}; nb = 0; cyc = 0; idle_run = 0; own = 0;
    while (nb < 4 && cyc < 80) begin
      g = gnt;
      for (int k = 0; k < 2; k++) begin
        rden[k] = 1'b1;
        last[k] = g[k] && (pos[k] == 1);
        idx[k*IW +: IW] = 3'(pos[k]);
      end
      #1;
      if (er_en) begin
        own = g[1] ? 1 : 0;
        if (pos[own] == 0) begin
          if (nb > 0) begin
            total++; if (idle_run !== 1) begin bad++; $display("FAIL alt_idle got=%0d exp=1", idle_run); end
          end
          ord[nb] = own;
        end
        if (pos[own] == 1) begin pos[own] = 0; nb++; end
        else pos[own]++;
        idle_run = 0;
      end else idle_run++;
      step(); cyc++;
    end
    rden = '0; last = '0;
    total++; if (nb !== 4) begin bad++; $display("FAIL alt_bound got=%0d bursts exp=4", nb); end
    for (int i = 0; i < 4; i++) begin
      total++; if (ord[i] !== i % 2) begin bad++; $display("FAIL alt_order burst%0d got=%0d exp=%0d", i, ord[i], i % 2); end
    end
    step();
  endtask

  task automatic test_gap();
    rden[0] = 1'b1; idx[0*IW +: IW] = 3'd0;
    step();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL gap_gnt0 got=%b exp=0001", gnt); end
    rden[1] = 1'b1;
    step();
    rden[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 total++; if (gnt !== 4'b0001 || er_en !== 1'b0) begin bad++; $display("FAIL gap_hold got=%b/%b exp=0001/0", gnt, er_en); end
      step();
    end
    rden[0] = 1'b1; last[0] = 1'b1; idx[0*IW +: IW] = 3'd1;
    step();
    rden[0] = 1'b0; last[0] = 1'b0;
    total++; if (gnt !== '0) begin bad++; $display("FAIL gap_release got=%b exp=0", gnt); end
    step();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL gap_next got=%b exp=0010", gnt); end
    last[1] = 1'b1; idx[1*IW +: IW] = 3'd5;
    step();
    rden = '0; last = '0;
    step();
  endtask

  task automatic test_timeout();
    rden[0] = 1'b1;
    step();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL to_gnt got=%b exp=0001", gnt); end
    rden[0] = 1'b0; rden[1] = 1'b1;
`ifdef USBFS_RDARB_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      total++; if (gnt !== 4'b0001 || tmo !== 1'b0) begin bad++; $display("FAIL to_stall got=%b/%b exp=0001/0", gnt, tmo); end
      step();
    end
    total++; if (tmo !== 1'b1 || gnt !== '0) begin bad++; $display("FAIL to_pulse got=%b/%b exp=1/0", tmo, gnt); end
    step();
    total++; if (gnt !== 4'b0010 || tmo !== 1'b0) begin bad++; $display("FAIL to_handover got=%b/%b exp=0010/0", gnt, tmo); end
`else
    for (int i = 0; i < TO + 4; i++) begin
      total++; if (gnt !== 4'b0001 || tmo !== 1'b0) begin bad++; $display("FAIL to_held got=%b/%b exp=0001/0", gnt, tmo); end
      step();
    end
    rden[0] = 1'b1; last[0] = 1'b1;
    step();
    rden[0] = 1'b0; last[0] = 1'b0;
    step();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL to_next got=%b exp=0010", gnt); end
`endif
    last[1] = 1'b1;
    step();
    rden = '0; last = '0;
    step();
  endtask

  task automatic test_reset_mid();
    rden[1] = 1'b1; idx[1*IW +: IW] = 3'd2;
    step(); step();
    idx[1*IW +: IW] = 3'd3;
    #2 rst = 1'b1;
    #1 total++; if ({gnt, rdv, er_en, busy, tmo} !== '0) begin bad++; $display("FAIL rstmid_outputs got=%b exp=0", {gnt, rdv, er_en, busy, tmo}); end
    rden = '0;
    step(); step();
    #2 rst = 1'b0; rden[0] = 1'b1; rden[1] = 1'b1;
    step();
    total++; if (gnt !== 4'b0001 || rdv !== '0) begin bad++; $display("FAIL rstmid_rr got=%b/%b exp=0001/0", gnt, rdv); end
    last[0] = 1'b1;
    step();
    rden = '0; last = '0;
    step();
  endtask

  task automatic test_soak();
    logic [N-1:0] want, g;
    want = '0;
    for (int c = 0; c < 3000; c++) begin
      g = gnt;
      for (int k = 0; k < N; k++) begin
        idx[k*IW +: IW] = 3'($urandom_range(0, 7));
        if (g[k]) begin
          rden[k] = ($urandom_range(0, 4) != 0);
          last[k] = rden[k] && ($urandom_range(0, 3) == 0);
          if (rden[k] && last[k]) want[k] = 1'b0;
        end else begin
          if (!want[k] && $urandom_range(0, 5) == 0) want[k] = 1'b1;
          rden[k] = want[k];
          last[k] = 1'($urandom_range(0, 1));
        end
      end
      step();
    end
    rden = '0; last = '0;
    step(); step();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
    test_reset();
    test_single();
    test_alternate();
    test_gap();
    test_timeout();
    test_reset_mid();
    test_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
